// File: rtl/svm_classifier_sdiv_26s_13s_15_seq_pkg.sv
// Shared types and constants for the sequential 26s/13s signed divider.
package svm_classifier_sdiv_26s_13s_15_seq_pkg;

  localparam int DIN0_W    = 26;
  localparam int DIN1_W    = 13;
  localparam int DOUT_W    = 15;
  localparam int DIV_ITERS = 26;
  localparam int CNT_W     = 5;

  // Saturation limits of the 15-bit signed quotient.
  localparam logic signed [DOUT_W-1:0] QMAX = 15'sh3FFF;  //  16383
  localparam logic signed [DOUT_W-1:0] QMIN = 15'sh4000;  // -16384

  // Iteration counter load value.
  localparam logic [CNT_W-1:0] CNT_LOAD = 5'd26;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/svm_classifier_sdiv_step.sv
// One combinational restoring-division step: shift the partial remainder /
// dividend pair left by one, trial-subtract the divisor magnitude and keep or
// restore. The quotient bit shifts into the vacated dividend LSB.
module svm_classifier_sdiv_step
  import svm_classifier_sdiv_26s_13s_15_seq_pkg::*;
(
  input  logic [DIN1_W-1:0] i_rem,
  input  logic [DIN0_W-1:0] i_dvd,
  input  logic [DIN1_W-1:0] i_dmag,
  output logic [DIN1_W-1:0] o_rem,
  output logic [DIN0_W-1:0] o_dvd,
  output logic              o_qbit
);

  logic [DIN1_W:0]   w_shift;
  logic [DIN1_W+1:0] w_diff;
  logic [DIN1_W:0]   w_sel;

  // Trial subtract with one guard bit; the guard bit acts as the borrow.
  always_comb begin
    w_shift = {i_rem, i_dvd[DIN0_W-1]};
    w_diff  = {1'b0, w_shift} - {2'b00, i_dmag};
    o_qbit  = ~w_diff[DIN1_W+1];
    if (o_qbit) begin
      w_sel = w_diff[DIN1_W:0];
    end else begin
      w_sel = w_shift;
    end
    // The kept remainder is below the divisor magnitude (<= 4096), so 13 bits hold it.
    o_rem = w_sel[DIN1_W-1:0];
    o_dvd = {i_dvd[DIN0_W-2:0], o_qbit};
  end

endmodule

// File: rtl/svm_classifier_sdiv_26s_13s_15_seq.sv
// Sequential signed radix-2 restoring divider, 26-bit dividend by 13-bit
// divisor, giving a saturated 15-bit quotient and a 13-bit remainder whose
// sign follows the dividend. Start/done handshake, fixed 28-cycle latency.
module svm_classifier_sdiv_26s_13s_15_seq
  import svm_classifier_sdiv_26s_13s_15_seq_pkg::*;
#(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 26,
  parameter int din1_WIDTH = 13,
  parameter int dout_WIDTH = 15
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic                         start,
  input  logic signed [din0_WIDTH-1:0] din0,
  input  logic signed [din1_WIDTH-1:0] din1,
  output logic                         busy,
  output logic                         done,
  output logic signed [dout_WIDTH-1:0] dout,
  output logic signed [din1_WIDTH-1:0] rem,
  output logic                         ovf,
  output logic                         dbz
);

  // The datapath is built for the package widths; other widths are rejected.
  if ((din0_WIDTH != DIN0_W) || (din1_WIDTH != DIN1_W) ||
      (dout_WIDTH != DOUT_W) || (ID < 0)) begin : g_cfg_err
    $error("svm_classifier_sdiv_26s_13s_15_seq: unsupported parameters");
  end

  state_e r_state;
  state_e w_state_nxt;

  logic [CNT_W-1:0]  r_cnt;
  logic [DIN1_W-1:0] r_rem_acc;
  logic [DIN0_W-1:0] r_dvd;
  logic [DIN1_W-1:0] r_dmag;
  logic              r_sign0;
  logic              r_sign1;

  logic                     r_busy;
  logic                     r_done;
  logic signed [DOUT_W-1:0] r_dout;
  logic signed [DIN1_W-1:0] r_rem;
  logic                     r_ovf;
  logic                     r_dbz;

  logic [DIN0_W:0]   w_dvd_abs;
  logic [DIN1_W-1:0] w_dmag;
  logic [DIN1_W-1:0] w_step_rem;
  logic [DIN0_W-1:0] w_step_dvd;
  logic              w_step_qbit;

  logic signed [DIN0_W:0]   w_q27;
  logic signed [DOUT_W-1:0] w_fix_dout;
  logic signed [DIN1_W-1:0] w_fix_rem;
  logic                     w_fix_ovf;
  logic                     w_fix_dbz;

  svm_classifier_sdiv_step u_step (
    .i_rem  (r_rem_acc),
    .i_dvd  (r_dvd),
    .i_dmag (r_dmag),
    .o_rem  (w_step_rem),
    .o_dvd  (w_step_dvd),
    .o_qbit (w_step_qbit)
  );

  // Operand magnitudes; -4096 maps to 4096 in the 13-bit unsigned magnitude.
  always_comb begin
    if (din0[DIN0_W-1]) begin
      w_dvd_abs = 27'd0 - {din0[DIN0_W-1], din0};
    end else begin
      w_dvd_abs = {1'b0, din0};
    end
    if (din1[DIN1_W-1]) begin
      w_dmag = 13'd0 - din1;
    end else begin
      w_dmag = din1;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = CALC;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      CALC: begin
        if (r_cnt == 5'd1) begin
          w_state_nxt = FIX;
        end else begin
          w_state_nxt = CALC;
        end
      end
      FIX:     w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Sign fix-up and saturation of the finished magnitudes.
  always_comb begin
    if (r_sign0 ^ r_sign1) begin
      w_q27 = 27'sd0 - $signed({1'b0, r_dvd});
    end else begin
      w_q27 = $signed({1'b0, r_dvd});
    end
    w_fix_dbz = (r_dmag == 13'd0);
    if (w_fix_dbz) begin
      w_fix_ovf  = 1'b1;
      w_fix_rem  = 13'sd0;
      w_fix_dout = r_sign0 ? QMIN : QMAX;
    end else begin
      if (r_sign0) begin
        w_fix_rem = 13'sd0 - $signed(r_rem_acc);
      end else begin
        w_fix_rem = $signed(r_rem_acc);
      end
      if (w_q27 > 27'sd16383) begin
        w_fix_ovf  = 1'b1;
        w_fix_dout = QMAX;
      end else if (w_q27 < -27'sd16384) begin
        w_fix_ovf  = 1'b1;
        w_fix_dout = QMIN;
      end else begin
        w_fix_ovf  = 1'b0;
        w_fix_dout = w_q27[DOUT_W-1:0];
      end
    end
  end

  // State register; reset wins over ce.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else if (ce) begin
      r_state <= w_state_nxt;
    end
  end

  // Operand capture and one restoring step per CALC cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= 5'd0;
      r_rem_acc <= 13'd0;
      r_dvd     <= 26'd0;
      r_dmag    <= 13'd0;
      r_sign0   <= 1'b0;
      r_sign1   <= 1'b0;
    end else if (ce) begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_cnt     <= CNT_LOAD;
            r_rem_acc <= 13'd0;
            r_dvd     <= w_dvd_abs[DIN0_W-1:0];
            r_dmag    <= w_dmag;
            r_sign0   <= din0[DIN0_W-1];
            r_sign1   <= din1[DIN1_W-1];
          end
        end
        CALC: begin
          r_cnt     <= r_cnt - 5'd1;
          r_rem_acc <= w_step_rem;
          r_dvd     <= w_step_dvd;
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  // Registered handshake and result outputs; results hold until the next FIX.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_dout <= 15'sd0;
      r_rem  <= 13'sd0;
      r_ovf  <= 1'b0;
      r_dbz  <= 1'b0;
    end else if (ce) begin
      r_busy <= (w_state_nxt == CALC) || (w_state_nxt == FIX);
      r_done <= (w_state_nxt == DONE);
      if (r_state == FIX) begin
        r_dout <= w_fix_dout;
        r_rem  <= w_fix_rem;
        r_ovf  <= w_fix_ovf;
        r_dbz  <= w_fix_dbz;
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign dout = r_dout;
  assign rem  = r_rem;
  assign ovf  = r_ovf;
  assign dbz  = r_dbz;

endmodule

// File: tb/tb_svm_classifier_sdiv_26s_13s_15_seq.sv
// Self-checking bench for the sequential signed divider: scoreboard of
// reference results computed from C-style integer division.
module tb_svm_classifier_sdiv_26s_13s_15_seq;

  logic               clk = 1'b0;
  logic               reset;
  logic               ce;
  logic               start;
  logic signed [25:0] din0;
  logic signed [12:0] din1;
  logic               busy;
  logic               done;
  logic signed [14:0] dout;
  logic signed [12:0] rem;
  logic               ovf;
  logic               dbz;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    longint q;
    longint r;
    longint ovf;
    longint dbz;
  } exp_t;

  exp_t sb_q[$];

  svm_classifier_sdiv_26s_13s_15_seq dut (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .start (start),
    .din0  (din0),
    .din1  (din1),
    .busy  (busy),
    .done  (done),
    .dout  (dout),
    .rem   (rem),
    .ovf   (ovf),
    .dbz   (dbz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp_v);
    n_checks++;
    if (obs != exp_v) begin
      n_errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t model(input longint a, input longint b);
    exp_t   e;
    longint q;
    if (b == 0) begin
      e.dbz = 1;
      e.ovf = 1;
      e.r   = 0;
      e.q   = (a < 0) ? -16384 : 16383;
    end else begin
      q     = a / b;
      e.r   = a % b;
      e.dbz = 0;
      if (q > 16383) begin
        e.q = 16383; e.ovf = 1;
      end else if (q < -16384) begin
        e.q = -16384; e.ovf = 1;
      end else begin
        e.q = q; e.ovf = 0;
      end
    end
    return e;
  endfunction

  // Issue one division, optionally stalling ce or pulsing a stray start, and
  // compare the result against the scoreboard entry when done appears.
  task automatic run_op(input longint a, input longint b, input int stall_at,
                        input int stall_len, input bit interfere, input string tag);
    int   cyc;
    bit   got;
    bit   busy_bad;
    bit   busy_at_done;
    exp_t e;
    @(negedge clk);
    din0  = a[25:0];
    din1  = b[12:0];
    start = 1'b1;
    sb_q.push_back(model(a, b));
    cyc = 0; got = 0; busy_bad = 0; busy_at_done = 0;
    while (!got && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        got = 1;
        busy_at_done = busy;
      end else if (!busy) begin
        busy_bad = 1;
      end
      start = 1'b0;
      if (interfere && cyc == 5) begin
        start = 1'b1;
        din0  = 26'sd12345;
        din1  = 13'sd11;
      end
      if (stall_len > 0 && cyc == stall_at) ce = 1'b0;
      if (stall_len > 0 && cyc == stall_at + stall_len) ce = 1'b1;
    end
    chk({tag, " done_seen"}, longint'(got), 1);
    e = sb_q.pop_front();
    if (got) begin
      chk({tag, " latency"}, cyc, 28 + stall_len);
      chk({tag, " busy_during"}, longint'(busy_bad), 0);
      chk({tag, " busy_at_done"}, longint'(busy_at_done), 0);
      chk({tag, " dout"}, dout, e.q);
      chk({tag, " rem"}, rem, e.r);
      chk({tag, " ovf"}, longint'(ovf), e.ovf);
      chk({tag, " dbz"}, longint'(dbz), e.dbz);
      @(negedge clk);
      chk({tag, " done_pulse"}, longint'(done), 0);
      chk({tag, " dout_hold"}, dout, e.q);
    end
  endtask

  longint tbl_a[13] = '{1000, -1000, 1000, -33554432, 33554431, -33554432, -5,
                        16383, -16384, 16384, -16385, 33554431, 5};
  longint tbl_b[13] = '{7, 7, -7, -4096, 1, 1, 0,
                        1, 1, 1, 1, -4096, 0};

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_done;
    reset = 1'b1; ce = 1'b1; start = 1'b0; din0 = 26'sd0; din1 = 13'sd0;
    repeat (3) @(negedge clk);
    chk("rst busy", longint'(busy), 0);
    chk("rst done", longint'(done), 0);
    chk("rst dout", dout, 0);
    chk("rst rem", rem, 0);
    chk("rst ovf", longint'(ovf), 0);
    chk("rst dbz", longint'(dbz), 0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      run_op(tbl_a[i], tbl_b[i], 0, 0, 1'b0, $sformatf("tbl%0d", i));
    end

    for (int i = 0; i < 6; i++) begin
      logic signed [25:0] ra;
      logic signed [12:0] rb;
      ra = 26'($urandom);
      rb = 13'($urandom);
      if (rb == 13'sd0) rb = 13'sd3;
      if (i < 3) ra = ra >>> (5'd10 + 5'(i));
      run_op(longint'(ra), longint'(rb), 0, 0, 1'b0, $sformatf("rnd%0d", i));
    end

    run_op(1000, 7, 10, 5, 1'b0, "stall");
    run_op(1000, 7, 0, 0, 1'b1, "stray_start");

    // Abort an operation with reset at cycle 10 of CALC.
    @(negedge clk);
    din0 = 26'sd1000; din1 = 13'sd7; start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort busy", longint'(busy), 0);
    chk("abort dout", dout, 0);
    chk("abort rem", rem, 0);
    chk("abort ovf", longint'(ovf), 0);
    chk("abort dbz", longint'(dbz), 0);
    saw_done = 0;
    for (int c = 0; c < 35; c++) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    chk("abort no_done", longint'(saw_done), 0);
    run_op(100, 3, 0, 0, 1'b0, "after_abort");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
